write_dac: RTL and testbench
============================

Name: write_dac

Overview:
- Transmit-side counterpart to the ADC read path.
- Takes an 8-bit sample from game logic, for example a paddle or tone level, through a valid/ready handshake.
- Drives it onto an 8-bit parallel DAC on the J-port header using the DAC's chip-select/write-strobe protocol with programmable setup, pulse and hold timing.
- Accepts one value per transaction and holds the last written value on the bus between transactions.

Parameters:
- SETUP_CYCLES, 2: cycles with cs_n low and data stable before wr_n falls. Legal range 1..255.
- PULSE_CYCLES, 3: cycles wr_n is held low. Legal range 1..255.
- HOLD_CYCLES, 1: cycles with wr_n high, cs_n low and data stable after wr_n rises. Legal range 1..255.
- SKIP_SAME, 0: when 1, an accepted value equal to the last written value completes without a bus cycle.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- Value  in  8  sample to write; sampled on handshake.
- value_valid  in  1  Value is valid.
- value_ready  out  1  block can accept a sample (registered).
- JPorts_out  out  8  DAC data bus.
- dac_cs_n  out  1  DAC chip select, active low.
- dac_wr_n  out  1  DAC write strobe, active low; DAC latches on rising edge.
- busy  out  1  transaction in progress (the inverse of value_ready).

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, JPorts_out=8'h00, dac_cs_n=1, dac_wr_n=1, value_ready=1, busy=0.
  - Counter cleared; last-value register=8'h00.
- Handshake: accept when value_valid && value_ready at a rising edge; Value is latched into JPorts_out on that same edge.
  - value_ready drops the cycle after acceptance.
  - value_valid while not ready is ignored; no queueing.
- States: IDLE, SETUP, STROBE, HOLD. One down-counter (8 bit) is loaded on each state entry with N-1.
- IDLE: cs_n=1, wr_n=1, ready=1.
  - On accept → SETUP.
  - If SKIP_SAME=1 and Value equals the last written value: stay IDLE, ready stays 1, no strobe.
- SETUP: cs_n=0, wr_n=1 for SETUP_CYCLES cycles → STROBE.
- STROBE: cs_n=0, wr_n=0 for PULSE_CYCLES cycles → HOLD.
- HOLD: cs_n=0, wr_n=1 for HOLD_CYCLES cycles → IDLE.
  - ready=1 on the first IDLE cycle.
  - A new accept is allowed on that cycle, giving back-to-back transactions.
- Timing, with accept at edge T:
  - cs_n low from T+1 to T+S+P+H inclusive.
  - wr_n low from T+1+S to T+S+P.
  - ready high at T+1+S+P+H.
  - Throughput: one write per S+P+H+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- JPorts_out changes only on an accept edge. It is stable for the whole cs_n-low window and retains its value in IDLE.
- The last-value register updates at the accept edge of a non-skipped write.
- Reset mid-transaction aborts immediately to the reset values (cs_n and wr_n high asynchronously). The partial write is discarded.
- Parameter values of 0 are illegal; flag them with an elaboration-time check.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, HOLD=2'd3);
  - DAC_WIDTH=8;
  - default timing constants, so the top level and the ADC-side read block use the same bus width.
- No sub-module is needed.
- Optional: a reusable cycle_timer (load/decrement/zero flag) if the team wants to share it with the PWM generator.

Test Plan:
- Reset check: hold reset=0 and toggle sys_clk → JPorts_out=8'h00, cs_n=1, wr_n=1, ready=1, busy=0.
- Single write, defaults: present Value=8'hA5 with valid for 1 cycle at T → JPorts_out=8'hA5 from T; cs_n low T+1..T+6; wr_n low T+3..T+5; ready=1 at T+7.
- Back-to-back writes: hold valid with 8'h10 then 8'h20 → second accept on the first ready cycle. Two complete strobe sequences; JPorts_out is 8'h10 throughout the first cs_n window and 8'h20 throughout the second.
- Busy ignore: pulse valid with 8'hFF mid-transaction → ignored; the bus keeps the prior value; no extra strobe.
- Skip same (SKIP_SAME=1): write 8'h3C twice → the second accept produces no cs_n or wr_n activity, and ready stays 1.
- Reset abort: assert reset during STROBE → cs_n and wr_n go high immediately (asynchronously), JPorts_out=8'h00. After release a fresh write of 8'h55 completes normally.

Source files
------------

// File: rtl/write_dac_pkg.sv
// Shared definitions for the DAC write path.
// Holds the state encoding, bus width and default timing constants so the
// write block and the ADC-side read block agree on the J-port bus width.
package write_dac_pkg;

  localparam int DAC_WIDTH = 8;

  // Default strobe timing, in sys_clk cycles.
  localparam int unsigned DEF_SETUP_CYCLES = 2;
  localparam int unsigned DEF_PULSE_CYCLES = 3;
  localparam int unsigned DEF_HOLD_CYCLES  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/write_dac.sv
// Parallel DAC writer.
// Accepts one 8-bit sample per valid/ready handshake and drives it onto the
// J-port DAC bus with a cs_n / wr_n strobe whose setup, pulse and hold widths
// are set by parameters. The bus keeps the last written value between writes.
//
// Ports:
//   sys_clk      in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   Value        in   sample to write, captured on handshake
//   value_valid  in   Value is valid
//   value_ready  out  block can accept a sample (registered)
//   JPorts_out   out  DAC data bus
//   dac_cs_n     out  DAC chip select, active low
//   dac_wr_n     out  DAC write strobe, active low (DAC latches on rise)
//   busy         out  transaction in progress, inverse of value_ready
//   dbg_state    out  current FSM state, for observation only
//
// Handshake: a sample transfers on a rising edge where value_valid and
// value_ready are both high. value_valid while value_ready is low is ignored
// and nothing is queued.
module write_dac
  import write_dac_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter bit          SKIP_SAME    = 1'b0
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic [DAC_WIDTH-1:0] Value,
  input  logic                 value_valid,
  output logic                 value_ready,
  output logic [DAC_WIDTH-1:0] JPorts_out,
  output logic                 dac_cs_n,
  output logic                 dac_wr_n,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255) begin : g_bad_setup
    $error("write_dac: SETUP_CYCLES must be in 1..255");
  end
  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 255) begin : g_bad_pulse
    $error("write_dac: PULSE_CYCLES must be in 1..255");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("write_dac: HOLD_CYCLES must be in 1..255");
  end

  // The counter is loaded with N-1 on state entry and the state is left
  // when it reads zero, so each phase lasts exactly N cycles.
  localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

  state_e               state_q;
  logic [7:0]           cnt_q;
  logic [DAC_WIDTH-1:0] data_q;
  logic [DAC_WIDTH-1:0] last_q;
  logic                 cs_n_q;
  logic                 wr_n_q;
  logic                 ready_q;
  logic                 busy_q;

  logic accept;
  logic skip;

  assign accept = value_valid && ready_q;
  assign skip   = SKIP_SAME && (Value == last_q);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_q <= Value;
            // A skipped write completes in the handshake itself: no bus
            // cycle, ready stays high.
            if (!skip) begin
              last_q  <= Value;
              state_q <= ST_SETUP;
              cnt_q   <= SETUP_LOAD;
              cs_n_q  <= 1'b0;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_STROBE;
            cnt_q   <= PULSE_LOAD;
            wr_n_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_HOLD;
            cnt_q   <= HOLD_LOAD;
            wr_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign value_ready = ready_q;
  assign JPorts_out  = data_q;
  assign dac_cs_n    = cs_n_q;
  assign dac_wr_n    = wr_n_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_write_dac.sv
// Bench for write_dac. Instance 0 runs with SKIP_SAME=0, instance 1 with
// SKIP_SAME=1. A transaction-level model records the accept cycle of each
// write and derives every expected output from its offset to that cycle.
module tb_write_dac;
  import write_dac_pkg::*;

  localparam int S = 2;
  localparam int P = 3;
  localparam int H = 1;
  localparam int L = S + P + H;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] in_v   [2];
  logic       in_vld [2];
  logic       rdy    [2];
  logic       cs_n   [2];
  logic       wr_n   [2];
  logic       bsy    [2];
  logic [7:0] bus    [2];
  logic [1:0] st     [2];

  write_dac #(.SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H), .SKIP_SAME(1'b0)) dut0 (
    .sys_clk(clk), .reset(rst_n), .Value(in_v[0]), .value_valid(in_vld[0]),
    .value_ready(rdy[0]), .JPorts_out(bus[0]), .dac_cs_n(cs_n[0]),
    .dac_wr_n(wr_n[0]), .busy(bsy[0]), .dbg_state(st[0])
  );

  write_dac #(.SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H), .SKIP_SAME(1'b1)) dut1 (
    .sys_clk(clk), .reset(rst_n), .Value(in_v[1]), .value_valid(in_vld[1]),
    .value_ready(rdy[1]), .JPorts_out(bus[1]), .dac_cs_n(cs_n[1]),
    .dac_wr_n(wr_n[1]), .busy(bsy[1]), .dbg_state(st[1])
  );

  // reference model
  int         cyc = 0;
  bit         m_act  [2];
  int         m_t    [2];
  logic [7:0] m_bus  [2];
  logic [7:0] m_last [2];
  int         m_acc  [2];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic bit m_ready(int i);
    return !m_act[i] || ((cyc - m_t[i]) >= L + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i]  = 1'b0;
        m_t[i]    = 0;
        m_bus[i]  = 8'h00;
        m_last[i] = 8'h00;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (in_vld[i] && m_ready(i)) begin
          m_acc[i] = m_acc[i] + 1;
          m_bus[i] = in_v[i];
          if (!(i == 1 && in_v[i] == m_last[i])) begin
            m_act[i]  = 1'b1;
            m_t[i]    = cyc;
            m_last[i] = in_v[i];
            if (i == 0) exp_q0.push_back(in_v[i]);
            else        exp_q1.push_back(in_v[i]);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks = n_checks + 1;
    assert (obs === exp_v) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  // Outputs seen after edge cyc describe cycle cyc+1 of the timing diagram.
  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      int         d;
      logic       in_win;
      logic       e_wr;
      logic [1:0] e_st;
      d      = m_act[i] ? (cyc + 1 - m_t[i]) : 0;
      in_win = (d >= 1) && (d <= L);
      e_wr   = !((d >= S + 1) && (d <= S + P));
      if (!in_win)          e_st = ST_IDLE;
      else if (d <= S)      e_st = ST_SETUP;
      else if (d <= S + P)  e_st = ST_STROBE;
      else                  e_st = ST_HOLD;
      chk($sformatf("cs_n%0d@%0d", i, cyc),  32'(cs_n[i]), 32'(!in_win));
      chk($sformatf("wr_n%0d@%0d", i, cyc),  32'(wr_n[i]), 32'(e_wr));
      chk($sformatf("ready%0d@%0d", i, cyc), 32'(rdy[i]),  32'(!in_win));
      chk($sformatf("busy%0d@%0d", i, cyc),  32'(bsy[i]),  32'(in_win));
      chk($sformatf("bus%0d@%0d", i, cyc),   32'(bus[i]),  32'(m_bus[i]));
      chk($sformatf("state%0d@%0d", i, cyc), 32'(st[i]),   32'(e_st));
    end
  endtask

  // Scoreboard: every wr_n rise must latch the next expected sample.
  always @(posedge wr_n[0]) begin
    if (rst_n) begin
      chk("strobe0_expected", 32'(exp_q0.size() > 0), 32'd1);
      if (exp_q0.size() > 0) chk("strobe0_data", 32'(bus[0]), 32'(exp_q0.pop_front()));
    end
  end

  always @(posedge wr_n[1]) begin
    if (rst_n) begin
      chk("strobe1_expected", 32'(exp_q1.size() > 0), 32'd1);
      if (exp_q1.size() > 0) chk("strobe1_data", 32'(bus[1]), 32'(exp_q1.pop_front()));
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_accept(input int i, input int bound);
    int a0;
    int k;
    a0 = m_acc[i];
    k  = 0;
    while (m_acc[i] == a0 && k < bound) begin
      step();
      k++;
    end
    chk($sformatf("accept%0d_in_time", i), 32'(m_acc[i] != a0), 32'd1);
  endtask

  task automatic drive_write(input int i, input logic [7:0] v);
    in_v[i]   = v;
    in_vld[i] = 1'b1;
    wait_accept(i, 40);
    in_vld[i] = 1'b0;
  endtask

  int t1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_v[i]   = 8'h00;
      in_vld[i] = 1'b0;
      m_acc[i]  = 0;
    end

    // reset held while the clock runs
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // single write with default timing
    drive_write(0, 8'hA5);
    idle(9);

    // back-to-back writes with valid held
    in_v[0]   = 8'h10;
    in_vld[0] = 1'b1;
    wait_accept(0, 40);
    t1 = m_t[0];
    in_v[0] = 8'h20;
    wait_accept(0, 40);
    in_vld[0] = 1'b0;
    chk("b2b_gap", 32'(m_t[0] - t1), 32'(L + 1));
    idle(9);

    // valid pulsed while busy is ignored
    drive_write(0, 8'h33);
    idle(2);
    in_v[0]   = 8'hFF;
    in_vld[0] = 1'b1;
    step();
    in_vld[0] = 1'b0;
    in_v[0]   = 8'h00;
    idle(8);

    // repeated value on the skipping instance
    drive_write(1, 8'h3C);
    idle(8);
    drive_write(1, 8'h3C);
    idle(4);
    drive_write(1, 8'h3D);
    idle(8);

    // randomized traffic on both instances
    for (int n = 0; n < 300; n++) begin
      in_vld[0] = 1'($urandom_range(0, 1));
      in_v[0]   = 8'($urandom);
      in_vld[1] = 1'($urandom_range(0, 1));
      in_v[1]   = 8'($urandom_range(0, 3));
      step();
    end
    in_vld[0] = 1'b0;
    in_vld[1] = 1'b0;
    idle(9);

    // reset in the middle of the strobe
    drive_write(0, 8'h77);
    idle(2);
    chk("abort_in_strobe", 32'(wr_n[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs();
    step();
    rst_n = 1'b1;
    idle(1);
    drive_write(0, 8'h55);
    idle(9);

    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
